// File: rtl/chan_mux_pkg.sv
// Shared types and width helpers for the registered channel selector.
package chan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } mux_state_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_mux_seq_if.sv
// Channel data bus plus the valid/ready output stream of chan_mux_seq.
interface chan_mux_seq_if #(
  parameter int N = 8,
  parameter int W = 8
);
  import chan_mux_pkg::*;
  localparam int SW = sel_width(N);

  logic [N*W-1:0] d;
  logic [W-1:0]   y;
  logic [SW-1:0]  y_ch;
  logic           y_valid;
  logic           out_ready;

  modport master (
    input  d,
    input  out_ready,
    output y,
    output y_ch,
    output y_valid
  );

  modport slave (
    output d,
    output out_ready,
    input  y,
    input  y_ch,
    input  y_valid
  );
endinterface

// File: rtl/chan_mux_dwell.sv
// Counts accepted samples on the current scan channel and flags the last one.
module chan_mux_dwell import chan_mux_pkg::*; #(
  parameter  int DWELL = 4,
  localparam int DW    = sel_width(DWELL)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic wrap
);

  localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

  logic [DW-1:0] cnt;

  assign wrap = inc && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chan_mux_seq.sv
// Registered N:1 channel selector with manual select, auto-scan and a
// valid/ready output register.
module chan_mux_seq import chan_mux_pkg::*; #(
  parameter  int N     = 8,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int SW    = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  input  logic [SW-1:0] sel_in,
  input  logic          sel_load,
  output logic          sel_err,
  chan_mux_seq_if.master bus
);

  localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  mux_state_t    state, state_nxt;
  logic [SW-1:0] cur;
  logic [W-1:0]  sel_data;
  logic          cap;
  logic          sel_ok;
  logic          scan_inc;
  logic          dwell_clr;
  logic          wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (en) state_nxt = mode ? SCAN : MANUAL;
  end

  // A new sample is taken whenever the output slot is empty or being drained.
  assign cap       = (state != IDLE) && (!bus.y_valid || bus.out_ready);
  assign sel_ok    = sel_load && ({1'b0, sel_in} < N_EXT);
  assign scan_inc  = cap && (state == SCAN);
  // Holding the counter clear outside SCAN makes every SCAN entry start fresh.
  assign dwell_clr = sel_ok || (state != SCAN);

  chan_mux_dwell #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dwell_clr),
    .inc   (scan_inc),
    .wrap  (wrap)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (cur == SW'(k)) sel_data = bus.d[k*W +: W];
    end
  end

  // An explicit load overrides the scan advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
    end else if (sel_ok) begin
      cur <= sel_in;
    end else if (wrap) begin
      cur <= (cur == LAST_CH) ? '0 : cur + 1'b1;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y       <= '0;
      bus.y_ch    <= '0;
      bus.y_valid <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      sel_err <= sel_load && !sel_ok;
      if (cap) begin
        bus.y       <= sel_data;
        bus.y_ch    <= cur;
        bus.y_valid <= 1'b1;
      end else if (bus.y_valid && bus.out_ready) begin
        bus.y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_seq.sv
// Self-checking bench for chan_mux_seq: an N=8/DWELL=4 instance and an
// N=10/DWELL=3 instance, checked against expectations derived from the rules.
module tb_chan_mux_seq;
  import chan_mux_pkg::*;

  localparam int N8  = 8;
  localparam int DW8 = 4;
  localparam int N10 = 10;
  localparam int DW10 = 3;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       en8, mode8, sel_load8, sel_err8;
  logic [2:0] sel_in8;
  logic       en10, mode10, sel_load10, sel_err10;
  logic [3:0] sel_in10;

  chan_mux_seq_if #(.N(N8),  .W(W)) bus8 ();
  chan_mux_seq_if #(.N(N10), .W(W)) bus10 ();

  chan_mux_seq #(.N(N8), .W(W), .DWELL(DW8)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .sel_in(sel_in8),
    .sel_load(sel_load8), .sel_err(sel_err8), .bus(bus8)
  );

  chan_mux_seq #(.N(N10), .W(W), .DWELL(DW10)) u10 (
    .clk(clk), .rst_n(rst_n), .en(en10), .mode(mode10), .sel_in(sel_in10),
    .sel_load(sel_load10), .sel_err(sel_err10), .bus(bus10)
  );

  int passed = 0;
  int total  = 0;
  logic [7:0] chd8  [N8];
  logic [7:0] chd10 [N10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en8 = 0; mode8 = 0; sel_load8 = 0; sel_in8 = '0;
    bus8.d = '0; bus8.out_ready = 0;
    en10 = 0; mode10 = 0; sel_load10 = 0; sel_in10 = '0;
    bus10.d = '0; bus10.out_ready = 0;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus8.y !== 8'h00) $display("FAIL rst8_y: got %0h want 0", bus8.y); else passed++;
    total++; if (bus8.y_ch !== 3'd0) $display("FAIL rst8_ych: got %0d want 0", bus8.y_ch); else passed++;
    total++; if (bus8.y_valid !== 1'b0) $display("FAIL rst8_vld: got %0b want 0", bus8.y_valid); else passed++;
    total++; if (sel_err8 !== 1'b0) $display("FAIL rst8_err: got %0b want 0", sel_err8); else passed++;
    total++; if (bus10.y !== 8'h00) $display("FAIL rst10_y: got %0h want 0", bus10.y); else passed++;
    total++; if (bus10.y_ch !== 4'd0) $display("FAIL rst10_ych: got %0d want 0", bus10.y_ch); else passed++;
    total++; if (bus10.y_valid !== 1'b0) $display("FAIL rst10_vld: got %0b want 0", bus10.y_valid); else passed++;
    total++; if (sel_err10 !== 1'b0) $display("FAIL rst10_err: got %0b want 0", sel_err10); else passed++;
    rst_n = 1;
    tick();
    total++; if (bus8.y_valid !== 1'b0) $display("FAIL idle_after_rst: got %0b want 0", bus8.y_valid); else passed++;
  endtask

  task automatic test_manual();
    int ch;
    logic [63:0] dv;
    logic [7:0]  exp_y;
    int          exp_ch;
    bus8.d = {$urandom(), $urandom()};
    bus8.d[5*8 +: 8] = 8'hA5;
    bus8.out_ready = 1;
    en8 = 1; mode8 = 0; sel_load8 = 1; sel_in8 = 3'd5;
    tick();
    sel_load8 = 0;
    tick();
    total++; if (bus8.y !== 8'hA5) $display("FAIL man_first_y: got %0h want a5", bus8.y); else passed++;
    total++; if (bus8.y_ch !== 3'd5) $display("FAIL man_first_ych: got %0d want 5", bus8.y_ch); else passed++;
    total++; if (bus8.y_valid !== 1'b1) $display("FAIL man_first_vld: got %0b want 1", bus8.y_valid); else passed++;
    ch = 5;
    for (int i = 0; i < 24; i++) begin
      dv = {$urandom(), $urandom()};
      bus8.d = dv;
      exp_y = dv[ch*8 +: 8];
      exp_ch = ch;
      sel_load8 = ($urandom() % 3) == 0;
      sel_in8 = 3'($urandom());
      if (sel_load8) ch = int'(sel_in8);
      tick();
      total++; if (bus8.y !== exp_y) $display("FAIL man_y[%0d]: got %0h want %0h", i, bus8.y, exp_y); else passed++;
      total++; if (int'(bus8.y_ch) != exp_ch) $display("FAIL man_ych[%0d]: got %0d want %0d", i, bus8.y_ch, exp_ch); else passed++;
      total++; if (bus8.y_valid !== 1'b1) $display("FAIL man_vld[%0d]: got %0b want 1", i, bus8.y_valid); else passed++;
    end
    sel_load8 = 0;
  endtask

  task automatic test_scan_backpressure();
    int k;
    int exp_ch;
    logic ordy, hold;
    logic [7:0] hy;
    logic [2:0] hch;
    for (int c = 0; c < N8; c++) begin
      chd8[c] = 8'($urandom());
      bus8.d[c*8 +: 8] = chd8[c];
    end
    bus8.out_ready = 1;
    mode8 = 1; sel_load8 = 1; sel_in8 = 3'd0;
    tick();
    sel_load8 = 0;
    tick();
    k = 0;
    for (int i = 0; i < 90; i++) begin
      if (i < 40) ordy = 1'b1;
      else if (i >= 50 && i < 53) ordy = 1'b0;
      else ordy = ($urandom() % 3) != 0;
      bus8.out_ready = ordy;
      if (bus8.y_valid && ordy) begin
        exp_ch = (k / DW8) % N8;
        total++; if (int'(bus8.y_ch) != exp_ch) $display("FAIL scan_ych[%0d]: got %0d want %0d", k, bus8.y_ch, exp_ch); else passed++;
        total++; if (bus8.y !== chd8[exp_ch]) $display("FAIL scan_y[%0d]: got %0h want %0h", k, bus8.y, chd8[exp_ch]); else passed++;
        k++;
      end
      hold = bus8.y_valid && !ordy;
      hy = bus8.y;
      hch = bus8.y_ch;
      tick();
      if (hold) begin
        total++; if (bus8.y !== hy || bus8.y_ch !== hch) $display("FAIL stall_hold[%0d]: got %0h/%0d want %0h/%0d", i, bus8.y, bus8.y_ch, hy, hch); else passed++;
        total++; if (bus8.y_valid !== 1'b1) $display("FAIL stall_vld[%0d]: got %0b want 1", i, bus8.y_valid); else passed++;
      end
      if (i < 40) begin
        total++; if (bus8.y_valid !== 1'b1) $display("FAIL scan_tput[%0d]: got %0b want 1", i, bus8.y_valid); else passed++;
      end
    end
    bus8.out_ready = 1;
  endtask

  task automatic test_simultaneous();
    int exp_ch;
    bus8.out_ready = 1;
    sel_load8 = 1; sel_in8 = 3'd7;
    tick();
    sel_load8 = 0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 4) begin sel_load8 = 1; sel_in8 = 3'd2; end
      tick();
      sel_load8 = 0;
      exp_ch = (e <= 4) ? 7 : ((e <= 8) ? 2 : 3);
      total++; if (int'(bus8.y_ch) != exp_ch) $display("FAIL simul_ych[%0d]: got %0d want %0d", e, bus8.y_ch, exp_ch); else passed++;
      total++; if (bus8.y !== chd8[exp_ch]) $display("FAIL simul_y[%0d]: got %0h want %0h", e, bus8.y, chd8[exp_ch]); else passed++;
    end
  endtask

  task automatic test_idle_hold();
    logic [7:0] hy;
    logic [2:0] hch;
    bus8.out_ready = 0;
    en8 = 0;
    hy = bus8.y;
    hch = bus8.y_ch;
    for (int i = 0; i < 4; i++) begin
      bus8.d = {$urandom(), $urandom()};
      mode8 = 1'($urandom());
      tick();
      total++; if (bus8.y !== hy || bus8.y_ch !== hch) $display("FAIL idle_hold[%0d]: got %0h/%0d want %0h/%0d", i, bus8.y, bus8.y_ch, hy, hch); else passed++;
      total++; if (bus8.y_valid !== 1'b1) $display("FAIL idle_vld[%0d]: got %0b want 1", i, bus8.y_valid); else passed++;
    end
    bus8.out_ready = 1;
    tick();
    total++; if (bus8.y_valid !== 1'b0) $display("FAIL idle_drain: got %0b want 0", bus8.y_valid); else passed++;
    tick();
    total++; if (bus8.y_valid !== 1'b0) $display("FAIL idle_nocap: got %0b want 0", bus8.y_valid); else passed++;
  endtask

  task automatic test_illegal_select();
    int exp_ch;
    for (int c = 0; c < N10; c++) begin
      chd10[c] = 8'($urandom());
      bus10.d[c*8 +: 8] = chd10[c];
    end
    bus10.out_ready = 1;
    sel_load10 = 1; sel_in10 = 4'd3;
    tick();
    sel_load10 = 0;
    total++; if (sel_err10 !== 1'b0) $display("FAIL idle_load_err: got %0b want 0", sel_err10); else passed++;
    en10 = 1; mode10 = 0;
    tick();
    tick();
    total++; if (bus10.y_ch !== 4'd3) $display("FAIL idle_load_ych: got %0d want 3", bus10.y_ch); else passed++;
    total++; if (bus10.y !== chd10[3]) $display("FAIL idle_load_y: got %0h want %0h", bus10.y, chd10[3]); else passed++;
    sel_load10 = 1; sel_in10 = 4'd9;
    tick();
    sel_load10 = 0;
    total++; if (sel_err10 !== 1'b0) $display("FAIL load9_err: got %0b want 0", sel_err10); else passed++;
    tick();
    total++; if (bus10.y_ch !== 4'd9) $display("FAIL load9_ych: got %0d want 9", bus10.y_ch); else passed++;
    total++; if (bus10.y !== chd10[9]) $display("FAIL load9_y: got %0h want %0h", bus10.y, chd10[9]); else passed++;
    sel_load10 = 1; sel_in10 = 4'd12;
    tick();
    sel_load10 = 0;
    total++; if (sel_err10 !== 1'b1) $display("FAIL load12_err: got %0b want 1", sel_err10); else passed++;
    tick();
    total++; if (sel_err10 !== 1'b0) $display("FAIL load12_pulse: got %0b want 0", sel_err10); else passed++;
    total++; if (bus10.y_ch !== 4'd9) $display("FAIL load12_ych: got %0d want 9", bus10.y_ch); else passed++;
    tick();
    total++; if (bus10.y_ch !== 4'd9) $display("FAIL load12_keep: got %0d want 9", bus10.y_ch); else passed++;
    mode10 = 1; sel_load10 = 1; sel_in10 = 4'd8;
    tick();
    sel_load10 = 0;
    for (int e = 0; e < 7; e++) begin
      tick();
      exp_ch = (8 + e / DW10) % N10;
      total++; if (int'(bus10.y_ch) != exp_ch) $display("FAIL scan10_ych[%0d]: got %0d want %0d", e, bus10.y_ch, exp_ch); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    en8 = 1; mode8 = 0; sel_load8 = 1; sel_in8 = 3'd3;
    bus8.d[3*8 +: 8] = 8'h5A;
    bus8.out_ready = 1;
    tick();
    sel_load8 = 0;
    tick();
    bus8.out_ready = 0;
    tick();
    total++; if (bus8.y_valid !== 1'b1 || bus8.y !== 8'h5A) $display("FAIL pre_rst: got %0b/%0h want 1/5a", bus8.y_valid, bus8.y); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (bus8.y !== 8'h00) $display("FAIL async_rst_y: got %0h want 0", bus8.y); else passed++;
    total++; if (bus8.y_ch !== 3'd0) $display("FAIL async_rst_ych: got %0d want 0", bus8.y_ch); else passed++;
    total++; if (bus8.y_valid !== 1'b0) $display("FAIL async_rst_vld: got %0b want 0", bus8.y_valid); else passed++;
    #1 rst_n = 1;
    bus8.out_ready = 1;
    tick();
    total++; if (bus8.y_valid !== 1'b0) $display("FAIL post_rst_lat: got %0b want 0", bus8.y_valid); else passed++;
    tick();
    total++; if (bus8.y_valid !== 1'b1) $display("FAIL post_rst_vld: got %0b want 1", bus8.y_valid); else passed++;
    total++; if (bus8.y_ch !== 3'd0) $display("FAIL post_rst_ych: got %0d want 0", bus8.y_ch); else passed++;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_backpressure();
    test_simultaneous();
    test_idle_hold();
    test_illegal_select();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/chan_mux_seq.md
# chan_mux_seq

Parametrised, registered N-channel, W-bit data selector: the sequential successor to the gate-level 8:1 mux. It adds a manual channel-select register, an auto-scan mode that cycles through the channels with a programmable dwell, and a valid/ready output handshake. It sits between multi-channel sample sources and a single downstream consumer.

## Interface
- `N`, 8: channel count, ≥2.
- `W`, 8: data width per channel.
- `DWELL`, 4: accepted samples per channel in scan mode, ≥1.
- `SW` (localparam): `$clog2(N)`, select width.

- `clk`  in  1: clock.
- `rst_n`  in  1: reset. **One clock; reset is asynchronous and active-low.**
- `en`  in  1: run enable.
- `mode`  in  1: 0 = manual, 1 = scan.
- `d`  in  N*W: channel data; channel k occupies `d[k*W +: W]`.
- `sel_in`  in  SW: channel to load.
- `sel_load`  in  1: load `sel_in` into the current-select register.
- `out_ready`  in  1: consumer accepts `y`.
- `y`  out  W: registered selected data.
- `y_ch`  out  SW: channel that `y` came from.
- `y_valid`  out  1: `y` holds an unaccepted sample.
- `sel_err`  out  1: one-cycle pulse when `sel_load` carries `sel_in >= N`.

## Operation
- FSM states: IDLE, MANUAL, SCAN. The state register is loaded every cycle: `en=0` → IDLE; `en=1, mode=0` → MANUAL; `en=1, mode=1` → SCAN.
- Capture condition: `cap = (state != IDLE) && (!y_valid || out_ready)`.
- On `cap`: `y <= d[cur*W +: W]`, `y_ch <= cur`, `y_valid <= 1`.
- Without `cap`: if `y_valid && out_ready`, clear `y_valid`; otherwise hold all outputs.
- Output stability: `y` and `y_ch` never change while `y_valid=1 && out_ready=0`.
- `sel_load` with `sel_in < N`: `cur <= sel_in`, `dwell <= 0`. This applies in any state, including IDLE.
- `sel_load` with `sel_in >= N`: `cur` is unchanged and `sel_err` pulses high for one cycle.
- SCAN: `dwell` increments on each `cap`.
  - When a `cap` occurs with `dwell == DWELL-1`: `dwell <= 0` and `cur <= (cur == N-1) ? 0 : cur+1`.
- Entering SCAN from any other state clears `dwell`.
- Leaving SCAN keeps `cur`.
- MANUAL: `dwell` is held at 0; `cur` changes only via `sel_load`.
- IDLE: no captures. A pending `y_valid` stays until it is accepted.

## Timing
- Reset values: `y=0`, `y_ch=0`, `y_valid=0`, `sel_err=0`, `cur=0`, `dwell=0`, state IDLE.
- `en` is sampled at edge t, so the state changes at t. The first capture happens at edge t+1, and `y_valid` is high after t+1.
- Steady state: `d` to `y` is 1 cycle. Throughput is 1 sample/cycle while `out_ready=1`.
- Same-cycle `cap` and `sel_load`: the capture uses the old `cur`; the new `cur` applies from the next capture.
- Same-cycle `sel_load` and scan advance: `sel_load` wins and `dwell` is cleared.
- `mode` or `en` toggling mid-stream never corrupts a held `y`. The handshake rules above always apply.
- Asserting `rst_n` mid-transfer immediately clears all outputs and state. An unaccepted sample is dropped.

## Structure
- Package `chan_mux_pkg`:
  - state enum `mux_state_t` {IDLE, MANUAL, SCAN};
  - width helper for `SW`.
- Sub-module `chan_mux_dwell`: DWELL counter with `clr`, `inc`, and a `wrap` output. It is instantiated once.
- The top level holds the FSM, the `cur` register, the output register, and the handshake logic.

## Test plan
- **Reset and manual select:** reset, then `en=1, mode=0`, `sel_load` 5, `d[5]=0xA5`. Expect `y=0xA5`, `y_ch=5`, `y_valid=1` two cycles after `en`.
- **Scan with N=8, DWELL=4:** hold `out_ready=1`. Expect `y_ch` to be 0,0,0,0,1,1,1,1,…,7×4, then wrap to 0.
- **Backpressure:** drop `out_ready` for 3 cycles mid-scan. Expect `y` and `y_ch` to stay frozen, and no sample to be lost or duplicated on resume; `dwell` resumes at the correct count.
- **Illegal select:** `sel_load` with `sel_in=9` at N=10, then `sel_in=12` at N=10. Expect the first to load; expect the second to pulse `sel_err` for one cycle with `cur` unchanged.
- **Simultaneous events:** `sel_load` 2 in the same cycle as a scan wrap 7→0. Expect `cur=2` and `dwell=0`; the capture in that cycle shows `y_ch=7`.
- **Reset mid-operation:** assert `rst_n=0` while `y_valid=1, out_ready=0`. Expect all outputs 0 immediately, without waiting for a clock edge.
